multi_strip_driver: RTL and testbench

Parallel WS281x-style serialiser that drives `NUM_STRIPS` LED strips at the same time from one byte-wide frame memory, with per-frame global brightness scaling and single-shot or continuous refresh. It replaces the single-strip driver: it sits between the frame-buffer RAM (read port) and the strip output pins. It prefetches the next byte for every strip while the current byte is being serialised, so the bit stream has no gaps between bytes.

---
 rtl/multi_strip_driver_if.sv | 11 +
 rtl/multi_strip_driver.sv | 188 ++++++++++++++++++
 tb/tb_multi_strip_driver.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_strip_driver_if.sv
// rtl/multi_strip_driver_if.sv - frame-buffer read port between the strip driver and its memory
interface multi_strip_driver_if #(
    parameter int ADDRESS_WIDTH = 13
);
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_read_enable;
    logic [7:0]               mem_data;

    modport master (output mem_addr, output mem_read_enable, input mem_data);
    modport slave  (input mem_addr, input mem_read_enable, output mem_data);
endinterface

// File: rtl/multi_strip_driver.sv
// rtl/multi_strip_driver.sv - parallel WS281x serialiser for several strips sharing one byte-wide frame memory
module multi_strip_driver #(
    parameter int NUM_STRIPS       = 4,
    parameter int LEDS_PER_STRIP   = 200,
    parameter int NUM_CHANNELS     = 3,
    parameter int CHANNEL_WIDTH    = 8,
    parameter int ADDRESS_WIDTH    = 13,
    parameter int BASE_ADDRESS     = 0,
    parameter int STRIP_STRIDE     = LEDS_PER_STRIP * NUM_CHANNELS,
    parameter int MEM_LATENCY      = 2,
    parameter int TOTAL_PULSE_TIME = 70,
    parameter int ZERO_PULSE_TIME  = 20,
    parameter int ONE_PULSE_TIME   = 50,
    parameter int RESET_PULSE_TIME = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    continuous,
    input  logic [7:0]              brightness,
    multi_strip_driver_if.master    mem,
    output logic [NUM_STRIPS-1:0]   strip_out,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int NUM_BYTES = LEDS_PER_STRIP * NUM_CHANNELS;
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int BIT_W     = (CHANNEL_WIDTH > 1) ? $clog2(CHANNEL_WIDTH) : 1;
    localparam int PULSE_W   = $clog2(TOTAL_PULSE_TIME);
    localparam int PW1       = PULSE_W + 1;
    localparam int WAIT_W    = $clog2(RESET_PULSE_TIME + NUM_STRIPS + MEM_LATENCY + 2);
    localparam int STRIP_W   = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
    localparam int FCNT_W    = $clog2(NUM_STRIPS + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PREFETCH = 2'd1;
    localparam logic [1:0] DRIVE    = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    localparam logic [BYTE_W-1:0]  LAST_BYTE     = BYTE_W'(NUM_BYTES - 1);
    localparam logic [BIT_W-1:0]   BIT_MSB       = BIT_W'(CHANNEL_WIDTH - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST    = PULSE_W'(TOTAL_PULSE_TIME - 1);
    localparam logic [PW1-1:0]     ONE_T         = PW1'(ONE_PULSE_TIME);
    localparam logic [PW1-1:0]     ZERO_T        = PW1'(ZERO_PULSE_TIME);
    localparam logic [WAIT_W-1:0]  PREFETCH_LAST = WAIT_W'(NUM_STRIPS + MEM_LATENCY);
    localparam logic [WAIT_W-1:0]  LATCH_LAST    = WAIT_W'(RESET_PULSE_TIME - 1);
    localparam logic [STRIP_W-1:0] STRIP_LAST    = STRIP_W'(NUM_STRIPS - 1);
    localparam logic [FCNT_W-1:0]  FCNT_N        = FCNT_W'(NUM_STRIPS);

    logic [1:0]               state;
    logic [WAIT_W-1:0]        wait_cnt;
    logic [BYTE_W-1:0]        byte_idx;
    logic [BIT_W-1:0]         bit_idx;
    logic [PULSE_W-1:0]       pulse;
    logic [7:0]               bright_q;
    logic [CHANNEL_WIDTH-1:0] shadow   [NUM_STRIPS];
    logic [CHANNEL_WIDTH-1:0] out_byte [NUM_STRIPS];
    logic [CHANNEL_WIDTH-1:0] cur_byte [NUM_STRIPS];
    logic [NUM_STRIPS-1:0]    level;
    logic [FCNT_W-1:0]        fetch_cnt;
    logic [MEM_LATENCY-1:0]   rd_pipe;
    logic [STRIP_W-1:0]       cap_idx;
    logic [16:0]              product;
    logic [7:0]               scaled;
    logic                     byte_start, latch_end, start_frame, fetch_go;
    logic [BYTE_W-1:0]        fetch_byte;

    assign byte_start  = (state == DRIVE) && (bit_idx == '0) && (pulse == '0);
    assign latch_end   = (state == LATCH) && (wait_cnt == LATCH_LAST);
    assign start_frame = ((state == IDLE) && (frame_start || continuous)) || (latch_end && continuous);
    assign fetch_go    = start_frame || (byte_start && (byte_idx != LAST_BYTE));
    assign fetch_byte  = start_frame ? '0 : byte_idx + BYTE_W'(1);
    assign product     = 17'(mem.mem_data) * (17'(bright_q) + 17'd1);
    assign scaled      = 8'(product >> 8);
    assign busy        = (state != IDLE);
    assign frame_done  = latch_end;

    // On bit 0 the shift register is only being loaded this cycle, so read the shadow directly.
    always_comb begin
        for (int s = 0; s < NUM_STRIPS; s++) begin
            cur_byte[s] = byte_start ? shadow[s] : out_byte[s];
            level[s]    = ({1'b0, pulse} < (cur_byte[s][BIT_MSB - bit_idx] ? ONE_T : ZERO_T));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            pulse     <= '0;
            bright_q  <= '0;
            strip_out <= '0;
        end else begin
            strip_out <= (state == DRIVE) ? level : '0;
            if (start_frame) begin
                bright_q <= brightness;
            end
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        state    <= PREFETCH;
                        wait_cnt <= '0;
                    end
                end
                PREFETCH: begin
                    if (wait_cnt == PREFETCH_LAST) begin
                        state    <= DRIVE;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        pulse    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DRIVE: begin
                    if (pulse == PULSE_LAST) begin
                        pulse <= '0;
                        if (bit_idx == BIT_MSB) begin
                            bit_idx <= '0;
                            if (byte_idx == LAST_BYTE) begin
                                state    <= LATCH;
                                wait_cnt <= '0;
                            end else begin
                                byte_idx <= byte_idx + BYTE_W'(1);
                            end
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        pulse <= pulse + PULSE_W'(1);
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        state    <= continuous ? PREFETCH : IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reads go out in strip order and return in the same order, so a wrapping index tracks captures.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem.mem_read_enable <= 1'b0;
            mem.mem_addr        <= ADDRESS_WIDTH'(BASE_ADDRESS);
            fetch_cnt           <= '0;
            rd_pipe             <= '0;
            cap_idx             <= '0;
            for (int s = 0; s < NUM_STRIPS; s++) begin
                shadow[s]   <= '0;
                out_byte[s] <= '0;
            end
        end else begin
            if (fetch_go) begin
                mem.mem_read_enable <= 1'b1;
                mem.mem_addr        <= ADDRESS_WIDTH'(BASE_ADDRESS) + ADDRESS_WIDTH'(fetch_byte);
                fetch_cnt           <= FCNT_W'(1);
            end else if (mem.mem_read_enable) begin
                if (fetch_cnt == FCNT_N) begin
                    mem.mem_read_enable <= 1'b0;
                end else begin
                    mem.mem_addr <= mem.mem_addr + ADDRESS_WIDTH'(STRIP_STRIDE);
                    fetch_cnt    <= fetch_cnt + FCNT_W'(1);
                end
            end
            rd_pipe[0] <= mem.mem_read_enable;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (rd_pipe[MEM_LATENCY-1]) begin
                shadow[cap_idx] <= CHANNEL_WIDTH'(scaled);
                cap_idx         <= (cap_idx == STRIP_LAST) ? '0 : cap_idx + STRIP_W'(1);
            end
            if (byte_start) begin
                for (int s = 0; s < NUM_STRIPS; s++) begin
                    out_byte[s] <= shadow[s];
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_strip_driver.sv
// tb/tb_multi_strip_driver.sv - scoreboard bench for multi_strip_driver
module tb_multi_strip_driver;
    localparam int NS = 2, NB = 6, T = 10, ZT = 3, OT = 7, RT = 40, ML = 2, STRIDE = 6;

    logic       clk = 1'b0, rst = 1'b0, frame_start = 1'b0, continuous = 1'b0;
    logic [7:0] brightness = 8'h00;
    logic [1:0] strip_out;
    logic       busy, frame_done;

    multi_strip_driver_if #(.ADDRESS_WIDTH(13)) bus ();

    multi_strip_driver #(
        .NUM_STRIPS(NS), .LEDS_PER_STRIP(2), .NUM_CHANNELS(3), .CHANNEL_WIDTH(8),
        .ADDRESS_WIDTH(13), .BASE_ADDRESS(0), .STRIP_STRIDE(STRIDE), .MEM_LATENCY(ML),
        .TOTAL_PULSE_TIME(T), .ZERO_PULSE_TIME(ZT), .ONE_PULSE_TIME(OT), .RESET_PULSE_TIME(RT)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .continuous(continuous),
        .brightness(brightness), .mem(bus), .strip_out(strip_out), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    logic [7:0] d1 = 8'h00, d2 = 8'h00;
    always @(posedge clk) begin
        d1 <= bus.mem_read_enable ? mem[bus.mem_addr[3:0]] : 8'h00;
        d2 <= d1;
    end
    assign bus.mem_data = d2;

    int total = 0, bad = 0, cyc = 0, done_cnt = 0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int         exp_addr [$];
    logic [7:0] want [12];
    logic [95:0] pat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, need);
        end
    endtask

    task automatic got_byte(input int s, input logic [7:0] v);
        logic [7:0] e;
        total++;
        if ((s == 0 && exp0.size() == 0) || (s == 1 && exp1.size() == 0)) begin
            bad++;
            $display("FAIL byte_s%0d: got %02h, want none", s, v);
        end else begin
            if (s == 0) e = exp0.pop_front();
            else        e = exp1.pop_front();
            if (v !== e) begin
                bad++;
                $display("FAIL byte_s%0d: got %02h, want %02h", s, v, e);
            end
        end
    endtask

    int         hcnt [NS];
    int         nbits [NS];
    logic [7:0] acc [NS];
    int         last_rise [NS];
    logic       prev_lvl [NS];
    logic       prev_busy = 1'b0;
    int         anchor = 0, first_rise = 0;
    bit         rise_pending = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) begin
                hcnt[s] = 0; nbits[s] = 0; acc[s] = 8'h00; last_rise[s] = -1; prev_lvl[s] = 1'b0;
            end
            rise_pending = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                anchor = cyc;
                rise_pending = 1'b1;
            end
            if (bus.mem_read_enable) begin
                total++;
                if (exp_addr.size() == 0) begin
                    bad++;
                    $display("FAIL read_addr: got %0d, want none", bus.mem_addr);
                end else begin
                    int a;
                    a = exp_addr.pop_front();
                    if (int'(bus.mem_addr) != a) begin
                        bad++;
                        $display("FAIL read_addr: got %0d, want %0d", bus.mem_addr, a);
                    end
                end
            end
            for (int s = 0; s < NS; s++) begin
                if (strip_out[s] && !prev_lvl[s]) begin
                    if (s == 0 && rise_pending) begin
                        chk("prefetch_latency", cyc - anchor, 6);
                        first_rise = cyc;
                        rise_pending = 1'b0;
                    end
                    if (last_rise[s] >= 0) chk("bit_period", cyc - last_rise[s], T);
                    last_rise[s] = cyc;
                    hcnt[s] = 1;
                end else if (strip_out[s]) begin
                    hcnt[s]++;
                end else if (prev_lvl[s]) begin
                    total++;
                    if (hcnt[s] == OT) acc[s] = {acc[s][6:0], 1'b1};
                    else begin
                        acc[s] = {acc[s][6:0], 1'b0};
                        if (hcnt[s] != ZT) begin
                            bad++;
                            $display("FAIL high_time_s%0d: got %0d, want %0d or %0d", s, hcnt[s], ZT, OT);
                        end
                    end
                    nbits[s]++;
                    if (nbits[s] == 8) begin
                        got_byte(s, acc[s]);
                        nbits[s] = 0;
                    end
                end
                prev_lvl[s] = strip_out[s];
            end
            if (frame_done) begin
                chk("frame_length", cyc - first_rise, 518);
                done_cnt++;
                anchor = cyc + 1;
                rise_pending = 1'b1;
                for (int s = 0; s < NS; s++) last_rise[s] = -1;
            end
        end
        prev_busy = busy;
    end

    task automatic load_mem(input logic [95:0] p);
        for (int i = 0; i < 12; i++) mem[i] = p[95-8*i -: 8];
    endtask

    task automatic set_want(input logic [95:0] p);
        for (int i = 0; i < 12; i++) want[i] = p[95-8*i -: 8];
    endtask

    task automatic push_frame();
        for (int k = 0; k < NB; k++) begin
            exp0.push_back(want[k]);
            exp1.push_back(want[NB+k]);
            exp_addr.push_back(k);
            exp_addr.push_back(STRIDE + k);
        end
    endtask

    task automatic start_frame(input logic [7:0] b);
        @(posedge clk); #1;
        brightness = b;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("frame_done_reached", (done_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic check_empty();
        chk("exp_bytes_left", exp0.size() + exp1.size(), 0);
        chk("exp_addr_left", exp_addr.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strip_out", int'(strip_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_read_enable", int'(bus.mem_read_enable), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        rst = 1'b1;

        pat = 96'h80_01_FF_00_AA_55_0F_F0_3C_C3_5A_A5;
        load_mem(pat);
        set_want(pat);
        push_frame();
        start_frame(8'd255);
        repeat (100) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        wait_done(1, 2000);
        chk("busy_fall", int'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("ignored_start_busy", int'(busy), 0);
        chk("ignored_start_frames", done_cnt, 1);
        check_empty();

        pat = 96'hFF_80_01_FF_FF_FF_FF_FF_FF_FF_FF_FF;
        load_mem(pat);
        pat = 96'h7F_40_00_7F_7F_7F_7F_7F_7F_7F_7F_7F;
        set_want(pat);
        push_frame();
        start_frame(8'd127);
        wait_done(2, 2000);
        check_empty();

        pat = 96'h0;
        set_want(pat);
        push_frame();
        start_frame(8'd0);
        wait_done(3, 2000);
        check_empty();

        pat = 96'h80_01_FF_00_AA_55_0F_F0_3C_C3_5A_A5;
        load_mem(pat);
        set_want(pat);
        push_frame();
        push_frame();
        @(posedge clk);
        #1 brightness = 8'd255;
        continuous = 1'b1;
        wait_done(4, 2000);
        chk("continuous_rearm_busy", int'(busy), 1);
        repeat (100) @(posedge clk);
        #1 continuous = 1'b0;
        wait_done(5, 2000);
        chk("continuous_stop_busy", int'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("continuous_frames", done_cnt, 5);
        check_empty();

        push_frame();
        start_frame(8'd255);
        repeat (200) @(posedge clk);
        #1 rst = 1'b0;
        exp0.delete();
        exp1.delete();
        exp_addr.delete();
        @(posedge clk);
        #1;
        chk("midrst_strip_out", int'(strip_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_mem_addr", int'(bus.mem_addr), 0);
        chk("midrst_read_enable", int'(bus.mem_read_enable), 0);
        rst = 1'b1;
        push_frame();
        start_frame(8'd255);
        wait_done(6, 2000);
        chk("restart_busy", int'(busy), 0);
        check_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
